window_builder: RTL and testbench
=================================

// Module: window_builder
// PURPOSE
//   Producer side of the filter data_bus interface. Accepts a raster-order pixel stream, buffers WIN-1 lines,
//   and presents each complete WIN x WIN neighbourhood on data_bus with a one-cycle refresh strobe.
//   Sits between the pixel source (memory reader) and the operation filter core, which consumes data_bus/refresh.
// PARAMETERS
//   PIX_W  10  bits per pixel
//   WIN    9   window edge length; data_bus width = WIN*WIN*PIX_W (810 by default)
//   IMG_W  64  pixels per line (>= WIN)
//   IMG_H  64  lines per frame (>= WIN)
// PORTS
//   clk          in   1              rising-edge clock
//   rst          in   1              asynchronous, active-low reset
//   pix_in       in   PIX_W          incoming pixel, raster order
//   pix_valid    in   1              pix_in valid this cycle; no backpressure
//   frame_start  in   1              qualifies by pix_valid; marks pixel (row 0, col 0)
//   data_bus     out  WIN*WIN*PIX_W  current window
//   refresh      out  1              1-cycle pulse: data_bus holds a new complete window
//   busy         out  1              high while in ACTIVE state
// BEHAVIOUR
//   Reset (rst=0, async): data_bus=0, refresh=0, busy=0, row=col=0, state=IDLE. Line-buffer RAM not cleared.
//   Bus layout: element (r,c) at data_bus[(r*WIN+c)*PIX_W +: PIX_W]; r=0 oldest line, c=0 oldest column;
//     element (WIN-1,WIN-1) is the pixel most recently accepted.
//   FSM: IDLE -> ACTIVE on pix_valid&frame_start; ACTIVE -> IDLE after accepting pixel (IMG_H-1, IMG_W-1).
//     In IDLE, pix_valid without frame_start is dropped (no state change, no refresh).
//     pix_valid&frame_start in ACTIVE: restart; that pixel becomes (0,0); prior partial lines are ignored.
//   Counters: col 0..IMG_W-1 wraps to 0 and increments row; row 0..IMG_H-1. Advance only on accepted pixels.
//   pix_valid=0: all state, data_bus and line buffers hold; refresh=0.
//   Window shift: on each accepted pixel, every window row shifts left one column; row WIN-1 takes pix_in,
//     rows 0..WIN-2 take the line-buffer taps for the same column from lines row-(WIN-1)..row-1.
//   refresh: asserted the cycle after accepting pixel (row,col) iff row>=WIN-1 and col>=WIN-1
//     (latency 1 clk, pix accept -> data_bus/refresh). No padding: (IMG_H-WIN+1)*(IMG_W-WIN+1) pulses per frame.
//   Line wrap: the first WIN-1 pixels of each line refill the shift register; no refresh until col=WIN-1.
//   Back-to-back frames: last pixel of frame and frame_start of next may be on consecutive cycles;
//     refresh for the last window still issues.
//   Reset mid-frame: immediate abort, outputs to reset values; next frame requires frame_start.
// CONFIGURATION
//   WINDOW_BUILDER_STATUS_EN defined: adds outputs frame_done (1 bit; pulses 1 clk with the final refresh
//     of a frame) and win_count (16 bits; windows emitted in current frame, cleared on frame_start, saturates).
//   Not defined: ports absent, no counter logic; all other behaviour identical.
// STRUCTURE
//   Package filter_pkg: PIX_W, WIN, BUS_W=WIN*WIN*PIX_W, state enum {IDLE, ACTIVE}; shared with operation.
//   Sub-module line_buffer (depth IMG_W, width PIX_W, 1-cycle read-before-write at col address);
//     WIN-1 instances chained: output of line k feeds input of line k-1.
//   Window shift register and FSM/counters are local to window_builder.
// TESTING  (bench uses IMG_W=16, IMG_H=12, WIN=9, PIX_W=10)
//   Ramp frame pix=row*16+col, continuous valid -> 8*4=32 refresh pulses; first at pixel (8,8),
//     element (0,0)=0x000 and (8,8)=0x088 (decimal 136); last window (8,8)=0x0BF (191).
//   Same ramp with pix_valid toggling 1/0 every cycle -> identical data_bus sequence, 32 pulses, holds when idle.
//   Pixels without frame_start from reset -> no refresh, busy stays 0; then frame_start -> normal frame.
//   frame_start re-asserted at pixel (5,3) -> restart; first refresh exactly 8*16+9 accepted pixels later.
//   rst pulsed low mid-row 9 -> data_bus=0, refresh=0, busy=0 immediately; next frame matches clean run.
//   With WINDOW_BUILDER_STATUS_EN: frame_done coincides with 32nd refresh, win_count=32 then clears on next frame_start.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared filter definitions: pixel/window geometry and the window_builder FSM states.
package filter_pkg;
    localparam int PIX_W = 10;
    localparam int WIN   = 9;
    localparam int BUS_W = WIN * WIN * PIX_W;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;
endpackage

// File: rtl/line_buffer.sv
// One raster line of pixel storage: registered read (read-before-write), single write port.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 10,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= din;
        end
        dout_reg <= mem[rd_addr];
    end

    assign dout = dout_reg;
endmodule

// File: rtl/window_builder.sv
// Builds WIN x WIN neighbourhoods from a raster pixel stream using WIN-1 chained line buffers.
// Optional WINDOW_BUILDER_STATUS_EN adds frame_done and win_count status outputs.
module window_builder
    import filter_pkg::*;
#(
    parameter int PIX_W = filter_pkg::PIX_W,
    parameter int WIN   = filter_pkg::WIN,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     frame_start,
    output logic [WIN*WIN*PIX_W-1:0] data_bus,
    output logic                     refresh,
    output logic                     busy
`ifdef WINDOW_BUILDER_STATUS_EN
    ,
    output logic                     frame_done,
    output logic [15:0]              win_count
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t           state_reg, state_next;
    logic [CW-1:0]    col_reg, col_next, col_acc;
    logic [RW-1:0]    row_reg, row_next, row_acc;
    logic             accept, restart, last_pix, emit;
    logic             refresh_reg;
    logic [PIX_W-1:0] win_reg [WIN][WIN];
    logic [PIX_W-1:0] tap     [WIN-1];
    logic [PIX_W-1:0] row_in  [WIN];

    // Coordinates of the pixel being accepted; a frame_start forces it to (0,0).
    always_comb begin
        restart  = pix_valid && frame_start;
        accept   = pix_valid && (frame_start || state_reg == ACTIVE);
        col_acc  = restart ? '0 : col_reg;
        row_acc  = restart ? '0 : row_reg;
        last_pix = (row_acc == RW'(IMG_H - 1)) && (col_acc == CW'(IMG_W - 1));
        emit     = accept && (row_acc >= RW'(WIN - 1)) && (col_acc >= CW'(WIN - 1));
    end

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (col_acc == CW'(IMG_W - 1)) begin
                col_next = '0;
                row_next = (row_acc == RW'(IMG_H - 1)) ? '0 : row_acc + 1'b1;
            end else begin
                col_next = col_acc + 1'b1;
                row_next = row_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (restart) state_next = ACTIVE;
            ACTIVE:  if (accept && last_pix) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ACTIVE);
    end

    // Prefetch the column the next accepted pixel will use so the tap is ready on accept.
    genvar gi;
    generate
        for (gi = 0; gi < WIN - 1; gi++) begin : g_line
            line_buffer #(
                .DEPTH(IMG_W),
                .WIDTH(PIX_W)
            ) u_line (
                .clk     (clk),
                .we      (accept),
                .wr_addr (col_acc),
                .din     (row_in[gi+1]),
                .rd_addr (col_next),
                .dout    (tap[gi])
            );
            assign row_in[gi] = tap[gi];
        end
        assign row_in[WIN-1] = pix_in;

        for (gi = 0; gi < WIN * WIN; gi++) begin : g_bus
            assign data_bus[gi*PIX_W +: PIX_W] = win_reg[gi / WIN][gi % WIN];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_reg[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_reg[r][c] <= win_reg[r][c+1];
                end
                win_reg[r][WIN-1] <= row_in[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_reg <= 1'b0;
        end else begin
            refresh_reg <= emit;
        end
    end

    assign refresh = refresh_reg;

`ifdef WINDOW_BUILDER_STATUS_EN
    logic        frame_done_reg;
    logic [15:0] win_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done_reg <= 1'b0;
            win_count_reg  <= '0;
        end else begin
            frame_done_reg <= emit && last_pix;
            if (restart) begin
                win_count_reg <= {15'd0, emit};
            end else if (emit && win_count_reg != 16'hFFFF) begin
                win_count_reg <= win_count_reg + 1'b1;
            end
        end
    end

    assign frame_done = frame_done_reg;
    assign win_count  = win_count_reg;
`endif
endmodule

// File: tb/tb_window_builder.sv
// Scoreboard bench for window_builder: a frame-array model predicts every window and refresh.
module tb_window_builder;
    localparam int PIX_W = 10;
    localparam int WIN   = 9;
    localparam int IMG_W = 16;
    localparam int IMG_H = 12;
    localparam int BW    = WIN * WIN * PIX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [PIX_W-1:0] pix_in = '0;
    logic             pix_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic [BW-1:0]    data_bus;
    logic             refresh;
    logic             busy;
`ifdef WINDOW_BUILDER_STATUS_EN
    logic             frame_done;
    logic [15:0]      win_count;
`endif

    window_builder #(
        .PIX_W(PIX_W),
        .WIN  (WIN),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .data_bus   (data_bus),
        .refresh    (refresh),
        .busy       (busy)
`ifdef WINDOW_BUILDER_STATUS_EN
        ,
        .frame_done (frame_done),
        .win_count  (win_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] win;
        bit            last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    // Reference model: the frame as a 2-D array plus the current raster position.
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    bit m_active = 0;
    int m_row = 0, m_col = 0, m_count = 0;
    bit acc_flag = 0, push_flag = 0, exp_busy = 0;
    int exp_cnt = 0;

    task automatic check(string name, bit ok, logic [BW-1:0] act, logic [BW-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    task automatic drive(bit v, bit fs, logic [PIX_W-1:0] p);
        exp_t e;
        @(negedge clk);
        pix_valid   = v;
        frame_start = fs;
        pix_in      = p;
        acc_flag    = 0;
        push_flag   = 0;
        if (v && (fs || m_active)) begin
            if (fs) begin
                m_active = 1; m_row = 0; m_col = 0; m_count = 0;
            end
            acc_flag = 1;
            img[m_row][m_col] = p;
            if (m_row >= WIN - 1 && m_col >= WIN - 1) begin
                for (int r = 0; r < WIN; r++)
                    for (int c = 0; c < WIN; c++)
                        e.win[(r*WIN+c)*PIX_W +: PIX_W] = img[m_row-WIN+1+r][m_col-WIN+1+c];
                e.last = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
                m_count++;
                exp_q.push_back(e);
                push_flag = 1;
            end
            if (m_col == IMG_W - 1) begin
                m_col = 0;
                if (m_row == IMG_H - 1) begin
                    m_row = 0;
                    m_active = 0;
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
        end
        exp_busy = m_active;
        exp_cnt  = m_count;
    endtask

    // gap: 0 continuous, 1 valid toggles every cycle, 2 random idle cycles
    task automatic run_frame(bit ramp, int gap);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                drive(1'b1, (r == 0 && c == 0),
                      ramp ? PIX_W'(r * IMG_W + c) : PIX_W'($urandom));
                if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0))
                    drive(1'b0, 1'b0, PIX_W'($urandom));
            end
        end
    endtask

    task automatic partial(int nr, int nc);
        for (int i = 0; i < nr * IMG_W + nc; i++)
            drive(1'b1, (i == 0), PIX_W'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        acc_flag = 0; push_flag = 0; m_active = 0; exp_busy = 0;
        m_count = 0; exp_cnt = 0;
        pix_valid = 1'b0; frame_start = 1'b0;
        #1;
        check("rst_data_bus", data_bus == '0, data_bus, '0);
        check("rst_refresh", refresh == 1'b0, BW'(refresh), '0);
        check("rst_busy", busy == 1'b0, BW'(busy), '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic expect_pulses(string name, int n);
        drive(1'b0, 1'b0, '0);
        check(name, pulses == n, BW'(pulses), BW'(n));
        check({name, "_queue"}, exp_q.size() == 0, BW'(exp_q.size()), '0);
        pulses = 0;
    endtask

    logic [BW-1:0] last_win = '0;
    bit armed = 0;

    always @(posedge clk) begin
        exp_t e;
        #2;
        check("busy", busy == exp_busy, BW'(busy), BW'(exp_busy));
`ifdef WINDOW_BUILDER_STATUS_EN
        check("win_count", win_count == 16'(exp_cnt), BW'(win_count), BW'(exp_cnt));
`endif
        if (!rst) begin
            armed = 0;
            check("refresh_in_reset", refresh == 1'b0, BW'(refresh), '0);
        end else if (refresh) begin
            if (!push_flag || exp_q.size() == 0) begin
                check("unexpected_refresh", 1'b0, BW'(1), '0);
            end else begin
                e = exp_q.pop_front();
                pulses++;
                check("window", data_bus == e.win, data_bus, e.win);
`ifdef WINDOW_BUILDER_STATUS_EN
                check("frame_done", frame_done == e.last, BW'(frame_done), BW'(e.last));
`endif
                last_win = e.win;
                armed = 1;
            end
        end else begin
            if (push_flag && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("missing_refresh", 1'b0, '0, BW'(1));
            end
`ifdef WINDOW_BUILDER_STATUS_EN
            check("frame_done_idle", frame_done == 1'b0, BW'(frame_done), '0);
`endif
            if (acc_flag) armed = 0;
            else if (armed) check("hold", data_bus == last_win, data_bus, last_win);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_data_bus", data_bus == '0, data_bus, '0);
        check("rst_refresh", refresh == 1'b0, BW'(refresh), '0);
        check("rst_busy", busy == 1'b0, BW'(busy), '0);
        rst = 1'b1;

        repeat (10) drive(1'b1, 1'b0, PIX_W'($urandom));
        expect_pulses("idle_drop", 0);

        run_frame(1'b1, 0);
        expect_pulses("ramp_pulses", 32);
        run_frame(1'b1, 1);
        expect_pulses("toggle_pulses", 32);
        run_frame(1'b0, 2);
        expect_pulses("random_gap_pulses", 32);

        partial(5, 3);
        run_frame(1'b0, 0);
        expect_pulses("restart_pulses", 32);

        run_frame(1'b0, 0);
        run_frame(1'b0, 0);
        expect_pulses("back_to_back_pulses", 64);

        partial(9, 5);
        do_reset();
        pulses = 0;
        exp_q.delete();
        repeat (3) drive(1'b1, 1'b0, PIX_W'($urandom));
        run_frame(1'b1, 0);
        expect_pulses("after_reset_pulses", 32);

        repeat (3) drive(1'b0, 1'b0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
